// File: rtl/sync_fifo_stream_reader.sv
// Drains a synchronous FIFO with 1-cycle read latency into a valid/ready stream.
// A 2-entry skid buffer (head/tail) keeps one word per cycle flowing under back-pressure.
module sync_fifo_stream_reader #(
  parameter int fifo_width = 32,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [fifo_width-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [fifo_width-1:0] m_data,
  output logic [cnt_width-1:0]  word_cnt,
  output logic                  busy
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [fifo_width-1:0] head_q, head_d;
  logic [fifo_width-1:0] tail_q, tail_d;
  logic [cnt_width-1:0]  cnt_q, cnt_d;
  logic                  pop;
  logic [2:0]            level;
  logic [1:0]            slot;

  assign m_valid  = (occ_q != 2'd0);
  assign pop      = m_valid & m_ready;
  // Words that will be buffered after this edge, counting the read already in flight.
  assign level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign slot     = occ_q - {1'b0, pop};

  assign fifo_rd_en = rst_n & en & ~fifo_empty & (level < 3'd2);
  assign m_data     = head_q;
  assign word_cnt   = cnt_q;
  assign busy       = inflight_q | m_valid;

  always_comb begin
    occ_d      = level[1:0];
    inflight_d = fifo_rd_en;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q + {{(cnt_width-1){1'b0}}, pop};
    if (pop) begin
      head_d = tail_q;
    end
    // The returning word lands in the first free slot after this cycle's pop.
    if (inflight_q) begin
      if (slot == 2'd0) begin
        head_d = fifo_data;
      end else begin
        tail_d = fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Random and directed stimulus for sync_fifo_stream_reader against an 8-deep FIFO model
// and a word-order / outstanding-count reference kept in the bench.
module tb_sync_fifo_stream_reader;
  localparam int W  = 32;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n, fifo_rst_n, en, m_ready;
  logic          fifo_empty, fifo_rd_en, m_valid, busy;
  logic [W-1:0]  fifo_data, m_data;
  logic [CW-1:0] word_cnt;

  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  mem [8];
  logic [2:0]    wp, rp;
  logic [3:0]    fcnt;

  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  wq [$];
  int            n_checks = 0, n_fail = 0;
  int            issued = 0, popped = 0, last_rd = 0, rd_pulses = 0;
  bit            hold_valid = 0, rst_low_prev = 0, rnd_ready = 0;
  logic [W-1:0]  hold_data;

  always #5 clk = ~clk;

  sync_fifo_stream_reader #(.fifo_width(W), .cnt_width(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // FIFO model: 8 deep, data_out valid the cycle after rd_en is sampled.
  assign fifo_empty = (fcnt == 4'd0);
  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      fcnt      <= '0;
      wp        <= '0;
      rp        <= '0;
      fifo_data <= '0;
      exp_q.delete();
    end else begin
      if (fifo_rd_en && fcnt != 4'd0) begin
        fifo_data <= mem[rp];
        rp        <= rp + 3'd1;
      end
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 3'd1;
        exp_q.push_back(wr_data);
      end
      fcnt <= fcnt + {3'b000, wr_en} - {3'b000, (fifo_rd_en && fcnt != 4'd0)};
    end
  end

  // Reference: outstanding words = reads issued - words popped; buffered = that minus last read.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_val("rst_rd_en", fifo_rd_en, 0);
      if (rst_low_prev) begin
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_word_cnt", word_cnt, 0);
        check_val("rst_m_data", m_data, 0);
      end
      issued = 0; popped = 0; last_rd = 0; hold_valid = 0;
      rst_low_prev = 1;
    end else begin
      rst_low_prev = 0;
      check_val("busy", busy, (issued - popped) != 0);
      check_val("m_valid", m_valid, (issued - last_rd - popped) > 0);
      check_val("word_cnt", word_cnt, popped[CW-1:0]);
      check_val("rd_guard", fifo_rd_en & (fifo_empty | ~en), 0);
      if (hold_valid) begin
        check_val("hold_valid", m_valid, 1);
        check_val("hold_data", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check_val("extra_word", 1, 0);
        else check_val("order", m_data, exp_q.pop_front());
        popped++;
      end
      hold_valid = m_valid & ~m_ready;
      hold_data  = m_data;
      issued    += int'(fifo_rd_en);
      rd_pulses += int'(fifo_rd_en);
      last_rd    = int'(fifo_rd_en);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (wq.size() > 0 && fcnt < 4'd8 && fifo_rst_n) begin
      wr_en   = 1'b1;
      wr_data = wq.pop_front();
    end
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int max_cyc, output int used);
    used = 0;
    while (used < max_cyc &&
           !(wq.size() == 0 && !wr_en && exp_q.size() == 0 && issued == popped)) begin
      step();
      used++;
    end
    check_val("drain_done", (wq.size() == 0 && exp_q.size() == 0 && issued == popped), 1);
  endtask

  task automatic sys_reset();
    step();
    rst_n = 1'b0; fifo_rst_n = 1'b0; wq.delete();
    step(); step();
    rst_n = 1'b1; fifo_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int used, lat, p0, got;
    rst_n = 0; fifo_rst_n = 0; en = 1; m_ready = 1; wr_en = 0; wr_data = '0;
    step(); step();

    // Reset held with a pre-filled FIFO: no reads may be issued.
    fifo_rst_n = 1;
    for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + 32'(i));
    repeat (6) step();
    @(negedge clk);
    check_val("rst_fifo_untouched", fcnt, 4);
    step();
    rst_n = 1;
    drain(100, used);
    sys_reset();

    // Full-rate stream of squares from a full FIFO.
    en = 0; m_ready = 1;
    for (int i = 0; i < 8; i++) wq.push_back(32'(i * i));
    repeat (9) step();
    en = 1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) begin lat = k; break; end
    end
    check_val("stream_latency", lat, 2);
    for (int i = 0; i < 8; i++) begin
      check_val("stream_valid", m_valid, 1);
      check_val("stream_data", m_data, 32'(i * i));
      @(negedge clk);
    end
    check_val("stream_cnt", word_cnt, 8);
    check_val("stream_idle", busy, 0);
    check_val("stream_fifo_empty", fifo_empty, 1);

    // Back-pressure: only two reads while the sink stalls.
    step();
    m_ready = 0;
    p0 = rd_pulses;
    for (int i = 0; i < 8; i++) wq.push_back(32'(i * 11));
    repeat (20) step();
    @(negedge clk);
    check_val("bp_rd_pulses", rd_pulses - p0, 2);
    check_val("bp_valid", m_valid, 1);
    check_val("bp_data", m_data, 0);
    p0 = popped;
    step();
    m_ready = 1;
    drain(100, used);
    check_val("bp_delivered", popped - p0, 8);

    // Empty FIFO: nothing read, then a single word with 2-cycle latency.
    step();
    p0 = rd_pulses;
    repeat (20) step();
    @(negedge clk);
    check_val("uf_no_reads", rd_pulses - p0, 0);
    check_val("uf_no_valid", m_valid, 0);
    wq.push_back(32'd100);
    step();
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fifo_rd_en) begin got = 1; break; end
      step();
    end
    check_val("uf_rd_seen", got, 1);
    @(negedge clk);
    check_val("uf_lat1_valid", m_valid, 0);
    @(negedge clk);
    check_val("uf_lat2_valid", m_valid, 1);
    check_val("uf_lat2_data", m_data, 100);
    drain(50, used);

    // Random ready with an enable pause mid-stream.
    rnd_ready = 1;
    wq.push_back(32'd1); wq.push_back(32'd10); wq.push_back(32'd100);
    step(); step();
    en = 0;
    repeat (5) step();
    en = 1;
    drain(200, used);

    // Long random run: random data, ready and enable.
    for (int i = 0; i < 300; i++) wq.push_back($urandom);
    for (int c = 0; c < 150; c++) begin
      step();
      en = ($urandom_range(0, 4) != 0);
    end
    en = 1;
    drain(5000, used);

    // Reset while one word is buffered and another is in flight.
    rnd_ready = 0;
    step();
    m_ready = 0;
    p0 = rd_pulses;
    for (int i = 0; i < 8; i++) wq.push_back(32'h5000 + 32'(i));
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      if (rd_pulses - p0 == 2) break;
    end
    step();
    @(negedge clk);
    check_val("mid_busy", busy, 1);
    check_val("mid_valid", m_valid, 1);
    #1;
    rst_n = 0; fifo_rst_n = 0; wq.delete();
    step();
    @(negedge clk);
    check_val("mid_rst_valid", m_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_cnt", word_cnt, 0);
    step();
    rst_n = 1; fifo_rst_n = 1; m_ready = 1;
    wq.push_back(32'd7);
    got = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      if (m_valid && m_ready) begin got = 1; break; end
    end
    check_val("post_rst_seen", got, 1);
    check_val("post_rst_data", m_data, 7);
    check_val("post_rst_cnt", word_cnt, 0);
    drain(50, used);

    // Sustained stream through the counter wrap (1 + 1100 words -> 1101 mod 1024).
    for (int i = 0; i < 1100; i++) wq.push_back($urandom);
    drain(3000, used);
    check_val("throughput", used <= 1110, 1);
    @(negedge clk);
    check_val("wrap_cnt", word_cnt, 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
